ysyx_22050550_csr_file: RTL

Machine-mode CSR storage and timer-interrupt sequencer. It is the receiving end of the writeback stage's CSR write port: it consumes the per-CSR write data and the 8-bit write-enable vector, and returns the current register values that writeback reads back. It also raises a timer-interrupt request toward the fetch/redirect logic and performs the hardware trap-entry update when that request is acknowledged.

---
 rtl/ysyx_22050550_csr_file.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ysyx_22050550_csr_file.sv
// Machine-mode CSR storage and timer-interrupt request/trap-entry sequencer.
// Optional mcycle/minstret counters are built only when YSYX_22050550_MCYCLE_EN is defined.
module ysyx_22050550_csr_file (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  wbcsren,
  input  logic [63:0] wbmepc,
  input  logic [63:0] wbmcause,
  input  logic [63:0] wbmtvec,
  input  logic [63:0] wbmstatus,
  input  logic [63:0] wbmie,
  input  logic [63:0] wbmip,
  input  logic        commit_valid,
  input  logic        mret_commit,
  input  logic        timer_irq,
  input  logic [63:0] irq_epc,
  input  logic        irq_ack,
  output logic [63:0] mepc,
  output logic [63:0] mcause,
  output logic [63:0] mtvec,
  output logic [63:0] mstatus,
  output logic [63:0] mie,
  output logic [63:0] mip,
  output logic        irq_req,
  output logic [63:0] irq_cause,
  output logic [63:0] mcycle,
  output logic [63:0] minstret
);

  localparam logic [63:0] MSTATUS_RESET = 64'h0000_000a_0000_1800;
  localparam logic [63:0] TIMER_CAUSE   = 64'h8000_0000_0000_0007;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      r_state;
  logic        r_irqReq;
  logic [63:0] r_mepc, r_mcause, r_mtvec, r_mstatus, r_mie, r_mip;
  logic        w_trapCond;
  logic        w_trapEntry;
  logic [63:0] w_trapMstatus;
  logic        w_unused;

  assign w_trapCond  = r_mstatus[3] & r_mie[7] & r_mip[7];
  assign w_trapEntry = (r_state == S_REQ) & irq_ack;

  always_comb begin
    w_trapMstatus        = r_mstatus;
    w_trapMstatus[7]     = r_mstatus[3];
    w_trapMstatus[3]     = 1'b0;
    w_trapMstatus[12:11] = 2'b11;
  end

  // Trap entry owns mepc/mcause/mstatus on the ack edge; mip[7] always mirrors the timer line.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mepc    <= '0;
      r_mcause  <= '0;
      r_mtvec   <= '0;
      r_mstatus <= MSTATUS_RESET;
      r_mie     <= '0;
      r_mip     <= '0;
    end else begin
      if (w_trapEntry) begin
        r_mepc    <= irq_epc;
        r_mcause  <= TIMER_CAUSE;
        r_mstatus <= w_trapMstatus;
      end else begin
        if (wbcsren[0]) r_mepc    <= wbmepc;
        if (wbcsren[1]) r_mcause  <= wbmcause;
        if (wbcsren[3]) r_mstatus <= wbmstatus;
      end
      if (wbcsren[2]) r_mtvec <= wbmtvec;
      if (wbcsren[4]) r_mie   <= wbmie;
      if (wbcsren[5]) begin
        r_mip[63:8] <= wbmip[63:8];
        r_mip[6:0]  <= wbmip[6:0];
      end
      r_mip[7] <= timer_irq;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_irqReq <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trapCond) begin
            r_state  <= S_REQ;
            r_irqReq <= 1'b1;
          end
        end
        S_REQ: begin
          if (irq_ack) begin
            r_state  <= S_WAIT;
            r_irqReq <= 1'b0;
          end else if (!w_trapCond) begin
            r_state  <= S_IDLE;
            r_irqReq <= 1'b0;
          end
        end
        S_WAIT: begin
          if (mret_commit) r_state <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_irqReq <= 1'b0;
        end
      endcase
    end
  end

`ifdef YSYX_22050550_MCYCLE_EN
  logic [63:0] r_mcycle, r_minstret;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
      if (commit_valid) r_minstret <= r_minstret + 64'd1;
    end
  end

  assign mcycle   = r_mcycle;
  assign minstret = r_minstret;
  assign w_unused = &{1'b0, wbcsren[7:6], wbmip[7]};
`else
  assign mcycle   = '0;
  assign minstret = '0;
  assign w_unused = &{1'b0, wbcsren[7:6], wbmip[7], commit_valid};
`endif

  assign mepc      = r_mepc;
  assign mcause    = r_mcause;
  assign mtvec     = r_mtvec;
  assign mstatus   = r_mstatus;
  assign mie       = r_mie;
  assign mip       = r_mip;
  assign irq_req   = r_irqReq;
  assign irq_cause = r_irqReq ? TIMER_CAUSE : 64'd0;

endmodule
